store_sequence_checker: RTL and testbench
=========================================

# store_sequence_checker

Synthesizable, parametrised self-check monitor for the RV32I pipelined core. Attaches to the core's memory-stage store bus, compares every data-memory write against a programmable table of expected (address, data) stores in order, and reports pass, mismatch or timeout. It extends the single-store pass/fail check to N ordered stores, an ignorable scratch address, a watchdog, and captured failure diagnostics, so it can run on FPGA as well as in simulation.

## Interface
- XLEN, 32: data/address width.
- NUM_EXP, 8: capacity of the expected-store table (≥1).
- TIMEOUT, 240: watchdog limit in cycles from start.
- IGNORE_ADDR, 96: scratch address whose stores are skipped when ign_en=1.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- tbl_we  in  1  write one table entry (accepted only in IDLE).
- tbl_idx  in  $clog2(NUM_EXP)  entry index.
- tbl_addr  in  XLEN  expected store address.
- tbl_data  in  XLEN  expected store data.
- start  in  1  one-cycle pulse: begin checking (IDLE only).
- exp_cnt  in  $clog2(NUM_EXP+1)  number of entries to check, latched at start; values >NUM_EXP saturate to NUM_EXP.
- ign_en  in  1  enable IGNORE_ADDR skipping, latched at start.
- mem_we  in  1  core MemWriteM.
- mem_addr  in  XLEN  core ALUResultM.
- mem_wdata  in  XLEN  core WriteDataM.
- done  out  1  checker reached a terminal state.
- pass  out  1  all exp_cnt stores matched in order.
- fail_code  out  2  0 none, 1 mismatch, 2 timeout.
- match_cnt  out  $clog2(NUM_EXP+1)  stores matched so far.
- fail_addr, fail_data  out  XLEN  offending store (mismatch only; else 0).
- cyc_cnt  out  $clog2(TIMEOUT+1)  cycles elapsed since start.

## Operation
- States: IDLE, RUN, PASS, FAIL, TMO. Reset → IDLE; all outputs 0; table contents not cleared.
- IDLE: tbl_we writes entry tbl_idx; mem_we ignored. start → RUN, ptr=0, cyc_cnt=0. tbl_we and start in same cycle: write performed, start honoured, written value used.
- start with exp_cnt=0 → PASS directly.
- RUN, each cycle cyc_cnt++. On mem_we:
  - ign_en=1 and mem_addr==IGNORE_ADDR → no effect.
  - addr and data equal entry[ptr] → match_cnt++, ptr++; if new match_cnt==exp_cnt → PASS.
  - otherwise → FAIL, fail_code=1, capture mem_addr/mem_wdata.
- Watchdog: if cyc_cnt reaches TIMEOUT in RUN and no terminal transition occurs that cycle → TMO, fail_code=2. A completing match or mismatch on the same cycle takes priority over timeout.
- Terminal states (PASS/FAIL/TMO) hold all outputs; mem_we ignored; leave only on start (→ RUN, counters/diagnostics cleared) or RST.
- RST mid-RUN: back to IDLE next edge, counters and diagnostics zero, table preserved.
- tbl_we outside IDLE ignored.

## Timing
- All outputs registered; store sampled at edge N reflected in match_cnt/done/pass/fail_* after edge N (visible cycle N+1).
- start sampled at edge N → cyc_cnt=0 and RUN from N+1; first cyc_cnt increment at N+2.
- One store evaluated per cycle; back-to-back stores each cycle supported.
- No combinational path from inputs to outputs.

## Structure
- Package store_checker_pkg: state enum (IDLE, RUN, PASS, FAIL, TMO), fail_code constants (FC_NONE, FC_MISMATCH, FC_TIMEOUT).
- Sub-module exp_store_table: NUM_EXP×(2·XLEN) register array, one synchronous write port, one combinational read port indexed by ptr; no reset on storage.
- Top holds FSM, ptr/match counter, watchdog, diagnostic registers.

## Test plan
- Load {(100,25)}, exp_cnt=1, ign_en=1; stores (96,7),(96,9),(100,25) → done=1, pass=1, match_cnt=1, fail_code=0 one cycle after third store.
- Load {(100,25),(104,7),(108,3)}, exp_cnt=3; stores (100,25),(104,8) → FAIL, fail_code=1, match_cnt=1, fail_addr=104, fail_data=8; later stores ignored.
- TIMEOUT=20, exp_cnt=1, no stores → done=1, fail_code=2 with cyc_cnt=20; matching store on cycle 20 instead → pass=1.
- ign_en=0, store (96,7) against entry (100,25) → FAIL, fail_addr=96.
- exp_cnt=0 start → pass=1 next cycle; exp_cnt=NUM_EXP+3 → behaves as NUM_EXP.
- RST asserted mid-RUN after 1 match → all outputs 0 next cycle; restart without reloading table passes with same store sequence.

Source files
------------

// File: rtl/store_sequence_checker_pkg.sv
// Shared types for the store sequence checker.
// state_t : checker FSM states.
// FC_*    : fail_code encodings reported on the bus.
package store_checker_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    PASS = 3'd2,
    FAIL = 3'd3,
    TMO  = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/store_sequence_checker_if.sv
// Bus bundle between the store sequence checker and its environment.
// master : environment side (table load, start/config, core store bus in;
//          status out).
// slave  : checker side.
interface store_sequence_checker_if #(
  parameter int XLEN    = 32,
  parameter int NUM_EXP = 8,
  parameter int TIMEOUT = 240
);
  localparam int IDXW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
  localparam int CNTW = $clog2(NUM_EXP + 1);
  localparam int CYCW = $clog2(TIMEOUT + 1);

  // table load / control
  logic            tbl_we;
  logic [IDXW-1:0] tbl_idx;
  logic [XLEN-1:0] tbl_addr;
  logic [XLEN-1:0] tbl_data;
  logic            start;
  logic [CNTW-1:0] exp_cnt;
  logic            ign_en;
  // core memory-stage store bus
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  // status
  logic            done;
  logic            pass;
  logic [1:0]      fail_code;
  logic [CNTW-1:0] match_cnt;
  logic [XLEN-1:0] fail_addr;
  logic [XLEN-1:0] fail_data;
  logic [CYCW-1:0] cyc_cnt;

  modport master (
    output tbl_we, tbl_idx, tbl_addr, tbl_data, start, exp_cnt, ign_en,
           mem_we, mem_addr, mem_wdata,
    input  done, pass, fail_code, match_cnt, fail_addr, fail_data, cyc_cnt
  );

  modport slave (
    input  tbl_we, tbl_idx, tbl_addr, tbl_data, start, exp_cnt, ign_en,
           mem_we, mem_addr, mem_wdata,
    output done, pass, fail_code, match_cnt, fail_addr, fail_data, cyc_cnt
  );
endinterface

// File: rtl/store_sequence_checker_exp_store_table.sv
// Expected-store table: NUM_EXP entries of {addr, data}.
// CLK          : clock.
// we/widx/waddr/wdata : synchronous write port.
// ridx -> raddr/rdata : combinational read port.
// Storage has no reset so a table survives a checker reset and can be rerun.
module exp_store_table #(
  parameter int XLEN    = 32,
  parameter int NUM_EXP = 8,
  parameter int IDXW    = 3
) (
  input  logic            CLK,
  input  logic            we,
  input  logic [IDXW-1:0] widx,
  input  logic [XLEN-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [IDXW-1:0] ridx,
  output logic [XLEN-1:0] raddr,
  output logic [XLEN-1:0] rdata
);
  logic [NUM_EXP-1:0][2*XLEN-1:0] mem;

  // Indices past NUM_EXP (non power-of-two sizes) are dropped on write and
  // read as zero.
  always_ff @(posedge CLK) begin
    if (we && (int'(widx) < NUM_EXP)) mem[widx] <= {waddr, wdata};
  end

  assign {raddr, rdata} = (int'(ridx) < NUM_EXP) ? mem[ridx] : '0;
endmodule

// File: rtl/store_sequence_checker.sv
// Ordered store self-check monitor for the RV32I core memory stage.
// CLK : clock (rising edge).  RST : synchronous active-high reset.
// bus : slave side of store_sequence_checker_if (table load, start,
//       core store bus in; done/pass/fail_code/match_cnt/fail_addr/
//       fail_data/cyc_cnt out, all decoded from registers).
module store_sequence_checker
  import store_checker_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          NUM_EXP     = 8,
  parameter int          TIMEOUT     = 240,
  parameter int unsigned IGNORE_ADDR = 96
) (
  input logic                  CLK,
  input logic                  RST,
  store_sequence_checker_if.slave bus
);
  localparam int IDXW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
  localparam int CNTW = $clog2(NUM_EXP + 1);
  localparam int CYCW = $clog2(TIMEOUT + 1);
  localparam logic [CYCW-1:0] CYC_LIMIT = CYCW'(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(NUM_EXP);
  localparam logic [XLEN-1:0] IGN_ADDR  = XLEN'(IGNORE_ADDR);

  state_t          state, stateNext;
  logic [CNTW-1:0] matchCnt, expCntQ, expSat;
  logic            ignEnQ;
  logic [CYCW-1:0] cycCnt, cycInc;
  logic [XLEN-1:0] failAddr, failData;
  logic [XLEN-1:0] entAddr, entData;
  logic [IDXW-1:0] ptr;
  logic            storeSeen, storeMatch, storeMiss, lastMatch;
  logic            doneQ, passQ;
  logic [1:0]      failCode;

  // The table pointer always equals the number of matches so far.
  assign ptr = matchCnt[IDXW-1:0];

  exp_store_table #(.XLEN(XLEN), .NUM_EXP(NUM_EXP), .IDXW(IDXW)) uTable (
    .CLK   (CLK),
    .we    (bus.tbl_we && (state == IDLE)),
    .widx  (bus.tbl_idx),
    .waddr (bus.tbl_addr),
    .wdata (bus.tbl_data),
    .ridx  (ptr),
    .raddr (entAddr),
    .rdata (entData)
  );

  assign expSat = (bus.exp_cnt > CNT_MAX) ? CNT_MAX : bus.exp_cnt;
  assign cycInc = cycCnt + 1'b1;

  // Store evaluation, only meaningful in RUN.
  assign storeSeen  = (state == RUN) && bus.mem_we &&
                      !(ignEnQ && (bus.mem_addr == IGN_ADDR));
  assign storeMatch = storeSeen && (bus.mem_addr == entAddr) &&
                      (bus.mem_wdata == entData);
  assign storeMiss  = storeSeen && !storeMatch;
  assign lastMatch  = storeMatch && ((matchCnt + 1'b1) == expCntQ);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state: a completing match or a mismatch outranks the watchdog.
  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (storeMiss)               stateNext = FAIL;
        else if (lastMatch)          stateNext = PASS;
        else if (cycInc == CYC_LIMIT) stateNext = TMO;
      end
      IDLE, PASS, FAIL, TMO: begin
        if (bus.start) stateNext = (expSat == '0) ? PASS : RUN;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    doneQ    = 1'b0;
    passQ    = 1'b0;
    failCode = FC_NONE;
    case (state)
      PASS: begin doneQ = 1'b1; passQ = 1'b1; end
      FAIL: begin doneQ = 1'b1; failCode = FC_MISMATCH; end
      TMO:  begin doneQ = 1'b1; failCode = FC_TIMEOUT; end
      default: ;
    endcase
  end

  // Counters, latched config and diagnostics. Outside RUN everything holds
  // until a start clears it; cycCnt freezes at TIMEOUT once in TMO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      matchCnt <= '0;
      expCntQ  <= '0;
      ignEnQ   <= 1'b0;
      cycCnt   <= '0;
      failAddr <= '0;
      failData <= '0;
    end else if (state != RUN) begin
      if (bus.start) begin
        matchCnt <= '0;
        expCntQ  <= expSat;
        ignEnQ   <= bus.ign_en;
        cycCnt   <= '0;
        failAddr <= '0;
        failData <= '0;
      end
    end else begin
      cycCnt <= cycInc;
      if (storeMatch) matchCnt <= matchCnt + 1'b1;
      if (storeMiss) begin
        failAddr <= bus.mem_addr;
        failData <= bus.mem_wdata;
      end
    end
  end

  assign bus.done      = doneQ;
  assign bus.pass      = passQ;
  assign bus.fail_code = failCode;
  assign bus.match_cnt = matchCnt;
  assign bus.fail_addr = failAddr;
  assign bus.fail_data = failData;
  assign bus.cyc_cnt   = cycCnt;
endmodule

// File: tb/tb_store_sequence_checker.sv
// Directed bench for store_sequence_checker with a per-cycle reference model.
module tb_store_sequence_checker;
  localparam int TMO_LIM = 20;
  localparam int NEXP    = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   nChk = 0;
  int   nErr = 0;

  always #5 CLK = ~CLK;

  store_sequence_checker_if #(.XLEN(32), .NUM_EXP(NEXP), .TIMEOUT(TMO_LIM)) bus ();

  store_sequence_checker #(
    .XLEN(32), .NUM_EXP(NEXP), .TIMEOUT(TMO_LIM), .IGNORE_ADDR(96)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 passed, 3 mismatch, 4 timeout.
  logic [31:0] tA [NEXP];
  logic [31:0] tD [NEXP];
  int          ph = 0, mCnt = 0, mExp = 0, mCyc = 0;
  bit          mIgn = 0;
  logic [31:0] mFa = 0, mFd = 0;

  always @(posedge CLK) begin
    if (RST) begin
      ph = 0; mCnt = 0; mExp = 0; mCyc = 0; mIgn = 0; mFa = 0; mFd = 0;
    end else if (ph == 1) begin
      mCyc++;
      if (bus.mem_we && !(mIgn && bus.mem_addr == 32'd96)) begin
        if (bus.mem_addr == tA[mCnt] && bus.mem_wdata == tD[mCnt]) begin
          mCnt++;
          if (mCnt == mExp) ph = 2;
        end else begin
          ph = 3; mFa = bus.mem_addr; mFd = bus.mem_wdata;
        end
      end
      if (ph == 1 && mCyc == TMO_LIM) ph = 4;
    end else begin
      if (ph == 0 && bus.tbl_we) begin
        tA[bus.tbl_idx] = bus.tbl_addr;
        tD[bus.tbl_idx] = bus.tbl_data;
      end
      if (bus.start) begin
        mExp = (int'(bus.exp_cnt) > NEXP) ? NEXP : int'(bus.exp_cnt);
        mIgn = bus.ign_en;
        mCnt = 0; mCyc = 0; mFa = 0; mFd = 0;
        ph   = (mExp == 0) ? 2 : 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("m_done", bus.done, (ph >= 2) ? 1 : 0);
    chk("m_pass", bus.pass, (ph == 2) ? 1 : 0);
    chk("m_fail_code", bus.fail_code, (ph == 3) ? 1 : (ph == 4) ? 2 : 0);
    chk("m_match_cnt", bus.match_cnt, mCnt);
    chk("m_fail_addr", bus.fail_addr, mFa);
    chk("m_fail_data", bus.fail_data, mFd);
    chk("m_cyc_cnt", bus.cyc_cnt, mCyc);
  end

  task automatic load(input int i, input int a, input int d);
    bus.tbl_we = 1'b1; bus.tbl_idx = 3'(i); bus.tbl_addr = a; bus.tbl_data = d;
    @(negedge CLK);
    bus.tbl_we = 1'b0;
  endtask

  task automatic go(input int n, input bit ign);
    bus.start = 1'b1; bus.exp_cnt = 4'(n); bus.ign_en = ign;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic store(input int a, input int d);
    bus.mem_we = 1'b1; bus.mem_addr = a; bus.mem_wdata = d;
    @(negedge CLK);
    bus.mem_we = 1'b0;
  endtask

  task automatic pulseRst();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic status(input string t, input int dn, input int ps, input int fc, input int mc);
    chk({t, "_done"}, bus.done, dn);
    chk({t, "_pass"}, bus.pass, ps);
    chk({t, "_fail_code"}, bus.fail_code, fc);
    chk({t, "_match_cnt"}, bus.match_cnt, mc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.tbl_we = 0; bus.tbl_idx = 0; bus.tbl_addr = 0; bus.tbl_data = 0;
    bus.start = 0; bus.exp_cnt = 0; bus.ign_en = 0;
    bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    repeat (2) @(negedge CLK);
    status("rst", 0, 0, 0, 0);
    chk("rst_cyc", bus.cyc_cnt, 0);
    RST = 1'b0;

    // 1: ignored scratch stores then a single match
    load(0, 100, 25);
    go(1, 1);
    store(96, 7); store(96, 9);
    status("t1_mid", 0, 0, 0, 0);
    store(100, 25);
    status("t1", 1, 1, 0, 1);
    chk("t1_cyc", bus.cyc_cnt, 3);
    // table write outside IDLE must not land; restart from PASS
    load(0, 200, 1);
    go(1, 1);
    store(100, 25);
    status("t1_rerun", 1, 1, 0, 1);

    // 2: mismatch on second store, later stores ignored
    pulseRst();
    load(0, 100, 25); load(1, 104, 7); load(2, 108, 3);
    go(3, 0);
    store(100, 25); store(104, 8);
    status("t2", 1, 0, 1, 1);
    chk("t2_fail_addr", bus.fail_addr, 104);
    chk("t2_fail_data", bus.fail_data, 8);
    store(108, 3);
    chk("t2_hold_match", bus.match_cnt, 1);
    chk("t2_hold_addr", bus.fail_addr, 104);

    // 3: watchdog, then a completing match on the limit cycle
    pulseRst();
    go(1, 0);
    repeat (TMO_LIM - 1) @(negedge CLK);
    status("t3_pre", 0, 0, 0, 0);
    chk("t3_pre_cyc", bus.cyc_cnt, TMO_LIM - 1);
    @(negedge CLK);
    status("t3", 1, 0, 2, 0);
    chk("t3_cyc", bus.cyc_cnt, TMO_LIM);
    @(negedge CLK);
    chk("t3_cyc_hold", bus.cyc_cnt, TMO_LIM);
    go(1, 0);
    repeat (TMO_LIM - 1) @(negedge CLK);
    store(100, 25);
    status("t3b", 1, 1, 0, 1);
    chk("t3b_cyc", bus.cyc_cnt, TMO_LIM);

    // 4: scratch address is checked when ign_en=0
    go(1, 0);
    store(96, 7);
    status("t4", 1, 0, 1, 0);
    chk("t4_fail_addr", bus.fail_addr, 96);
    chk("t4_fail_data", bus.fail_data, 7);

    // 5: exp_cnt=0 passes at once; oversize exp_cnt saturates
    go(0, 0);
    status("t5a", 1, 1, 0, 0);
    pulseRst();
    for (int i = 0; i < NEXP; i++) load(i, 200 + 4 * i, 3 * i + 1);
    go(NEXP + 3, 0);
    for (int i = 0; i < NEXP - 1; i++) store(200 + 4 * i, 3 * i + 1);
    status("t5b_mid", 0, 0, 0, NEXP - 1);
    store(200 + 4 * (NEXP - 1), 3 * (NEXP - 1) + 1);
    status("t5b", 1, 1, 0, NEXP);
    store(1, 1);
    status("t5b_hold", 1, 1, 0, NEXP);

    // 6: reset mid-run, table survives
    pulseRst();
    go(2, 0);
    store(200, 1);
    chk("t6_mid_match", bus.match_cnt, 1);
    RST = 1'b1;
    @(negedge CLK);
    status("t6_rst", 0, 0, 0, 0);
    chk("t6_rst_cyc", bus.cyc_cnt, 0);
    chk("t6_rst_faddr", bus.fail_addr, 0);
    RST = 1'b0;
    go(2, 0);
    store(200, 1); store(204, 4);
    status("t6", 1, 1, 0, 2);

    // 7: table write and start in the same IDLE cycle
    pulseRst();
    bus.tbl_we = 1'b1; bus.tbl_idx = 3'd0; bus.tbl_addr = 300; bus.tbl_data = 5;
    bus.start = 1'b1; bus.exp_cnt = 4'd1; bus.ign_en = 1'b0;
    @(negedge CLK);
    bus.tbl_we = 1'b0; bus.start = 1'b0;
    store(300, 5);
    status("t7", 1, 1, 0, 1);

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
